alu: RTL and testbench



---
 rtl/alu.sv | 120 ++++++++++++
 tb/tb_alu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
//==============================================================================
// Module      : alu
// Description : 32-bit integer ALU for the execute stage. ADD, SUB, AND, OR,
//               SLL and SRA on two's-complement operands, plus signed
//               less-than and not-equal flags for branch resolution.
//               Compile-time option: define ALU_OUTPUT_REG_EN to register
//               all outputs (one-cycle latency, async active-low reset).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan
);

  localparam logic [4:0] c_opAdd = 5'd0;
  localparam logic [4:0] c_opSub = 5'd1;
  localparam logic [4:0] c_opAnd = 5'd2;
  localparam logic [4:0] c_opOr  = 5'd3;
  localparam logic [4:0] c_opSll = 5'd4;
  localparam logic [4:0] c_opSra = 5'd5;

  logic        w_isSub;
  logic [31:0] w_addendB;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_overflow;
  logic        w_lessThan;
  logic        w_notEqual;
  logic [31:0] w_result;

  // Stage k of each shifter holds the operand after applying shift bits [k-1:0].
  logic [5:0][31:0] w_sllStage;
  logic [5:0][31:0] w_sraStage;

  // Shared adder: subtraction is A + ~B + 1 via the inverted addend and carry-in.
  assign w_isSub   = (ctrl_ALUopcode == c_opSub);
  assign w_addendB = w_isSub ? ~data_operandB : data_operandB;
  assign w_sum     = data_operandA + w_addendB + {31'd0, w_isSub};

  // Dedicated comparator subtractor so flags are valid for every opcode.
  assign w_diff     = data_operandA + ~data_operandB + 32'd1;
  assign w_overflow = (data_operandA[31] != data_operandB[31]) &&
                      (w_diff[31] != data_operandA[31]);
  assign w_lessThan = w_diff[31] ^ w_overflow;
  assign w_notEqual = |w_diff;

  assign w_sllStage[0] = data_operandA;
  assign w_sraStage[0] = data_operandA;

  // Log-depth barrel shifters: stage s moves by 2**s when shift bit s is set.
  generate
    for (genvar s = 0; s < 5; s++) begin : g_shiftStage
      localparam int c_dist = 1 << s;
      assign w_sllStage[s+1] = ctrl_shiftamt[s]
          ? {w_sllStage[s][31-c_dist:0], {c_dist{1'b0}}}
          : w_sllStage[s];
      assign w_sraStage[s+1] = ctrl_shiftamt[s]
          ? {{c_dist{w_sraStage[s][31]}}, w_sraStage[s][31:c_dist]}
          : w_sraStage[s];
    end
  endgenerate

  // Result select; undefined opcodes yield zero.
  always_comb begin
    w_result = 32'd0;
    case (ctrl_ALUopcode)
      c_opAdd: w_result = w_sum;
      c_opSub: w_result = w_sum;
      c_opAnd: w_result = data_operandA & data_operandB;
      c_opOr:  w_result = data_operandA | data_operandB;
      c_opSll: w_result = w_sllStage[5];
      c_opSra: w_result = w_sraStage[5];
      default: w_result = 32'd0;
    endcase
  end

`ifdef ALU_OUTPUT_REG_EN
  logic [31:0] r_result;
  logic        r_notEqual;
  logic        r_lessThan;

  // Output register stage, cleared asynchronously while reset is low.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_result   <= 32'd0;
      r_notEqual <= 1'b0;
      r_lessThan <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_notEqual <= w_notEqual;
      r_lessThan <= w_lessThan;
    end
  end

  assign data_result = r_result;
  assign isNotEqual  = r_notEqual;
  assign isLessThan  = r_lessThan;
`else
  // Clock and reset are intentionally unused in the combinational build.
  logic w_unusedClockReset;
  assign w_unusedClockReset = clock ^ ctrl_reset;

  assign data_result = w_result;
  assign isNotEqual  = w_notEqual;
  assign isLessThan  = w_lessThan;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
//==============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu: directed vector table, reset and
//               mid-run reset sequences, and randomized regression against a
//               behavioural model at several clock rates.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [4:0]  ctrl_ALUopcode = 5'd0;
  logic [4:0]  ctrl_shiftamt = 5'd0;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;

  int  testsRun = 0;
  int  testsFailed = 0;
  real halfPeriod = 10.0;

  alu dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan)
  );

  always begin
    #(halfPeriod) clock = ~clock;
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] expResult;
    logic        expNe;
    logic        expLt;
  } vec_t;

  vec_t vecs[18];

  // Behavioural reference: plain language-level arithmetic on the operands.
  function automatic logic [31:0] refResult(logic [4:0] op, logic [31:0] a,
                                            logic [31:0] b, logic [4:0] sh);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refLt(logic [31:0] a, logic [31:0] b);
    return $signed(a) < $signed(b);
  endfunction

  task automatic checkOut(string name, logic [31:0] expR, logic expNe, logic expLt);
    testsRun += 3;
    if (data_result !== expR) begin
      testsFailed++;
      $display("FAIL %s result: got %h want %h", name, data_result, expR);
    end
    if (isNotEqual !== expNe) begin
      testsFailed++;
      $display("FAIL %s isNotEqual: got %b want %b", name, isNotEqual, expNe);
    end
    if (isLessThan !== expLt) begin
      testsFailed++;
      $display("FAIL %s isLessThan: got %b want %b", name, isLessThan, expLt);
    end
  endtask

  // Drive on the falling edge; sample after settle (and after capture edge if registered).
  task automatic applyOp(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic [4:0] sh);
    @(negedge clock);
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
`ifdef ALU_OUTPUT_REG_EN
    @(posedge clock);
`endif
    #0.5;
  endtask

  task automatic applyModel(string name, logic [31:0] a, logic [31:0] b,
                            logic [4:0] op, logic [4:0] sh);
    applyOp(a, b, op, sh);
    checkOut(name, refResult(op, a, b, sh), (a != b), refLt(a, b));
  endtask

  initial begin
    real periods[4];
    periods = '{20.0, 10.0, 5.0, 3.333};

    vecs[0]  = '{"add_wrap",   32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 5'd0,  32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{"sub_neg",    32'h0000_0005, 32'h0000_0007, 5'd1, 5'd0,  32'hFFFF_FFFE, 1'b1, 1'b1};
    vecs[2]  = '{"and",        32'hF0F0_1234, 32'h0FF0_FF00, 5'd2, 5'd0,  32'h00F0_1200, 1'b1, 1'b1};
    vecs[3]  = '{"or",         32'hF0F0_1234, 32'h0FF0_FF00, 5'd3, 5'd0,  32'hFFF0_FF34, 1'b1, 1'b1};
    vecs[4]  = '{"sll4",       32'h8000_0001, 32'h0000_0000, 5'd4, 5'd4,  32'h0000_0010, 1'b1, 1'b1};
    vecs[5]  = '{"sra4",       32'h8000_0001, 32'h0000_0000, 5'd5, 5'd4,  32'hF800_0000, 1'b1, 1'b1};
    vecs[6]  = '{"sra0",       32'h8000_0001, 32'h0000_0000, 5'd5, 5'd0,  32'h8000_0001, 1'b1, 1'b1};
    vecs[7]  = '{"lt_minint",  32'h8000_0000, 32'h0000_0001, 5'd0, 5'd0,  32'h8000_0001, 1'b1, 1'b1};
    vecs[8]  = '{"lt_maxint",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd0,  32'h8000_0000, 1'b1, 1'b0};
    vecs[9]  = '{"equal",      32'h1234_5678, 32'h1234_5678, 5'd2, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
    vecs[10] = '{"op7_zero",   32'h0000_0003, 32'h0000_0004, 5'd7, 5'd3,  32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{"op31_zero",  32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 5'd9, 32'h0000_0000, 1'b1, 1'b1};
    vecs[12] = '{"sll31_one",  32'h0000_0001, 32'h0000_0000, 5'd4, 5'd31, 32'h8000_0000, 1'b1, 1'b0};
    vecs[13] = '{"sll31_zero", 32'h0000_0002, 32'h0000_0000, 5'd4, 5'd31, 32'h0000_0000, 1'b1, 1'b0};
    vecs[14] = '{"sra31_neg",  32'h8000_0000, 32'h0000_0000, 5'd5, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[15] = '{"sra31_pos",  32'h7FFF_FFFF, 32'h0000_0000, 5'd5, 5'd31, 32'h0000_0000, 1'b1, 1'b0};
    vecs[16] = '{"sll_ignB",   32'h0000_00FF, 32'hDEAD_BEEF, 5'd4, 5'd8,  32'h0000_FF00, 1'b1, 1'b0};
    vecs[17] = '{"sub_eq0",    32'hCAFE_0000, 32'hCAFE_0000, 5'd1, 5'd0,  32'h0000_0000, 1'b0, 1'b0};

    // Reset state: registered build clears outputs; combinational build ignores reset.
    data_operandA  = 32'd5;
    data_operandB  = 32'd3;
    ctrl_ALUopcode = 5'd0;
    repeat (3) @(posedge clock);
    #1;
`ifdef ALU_OUTPUT_REG_EN
    checkOut("reset_hold", 32'd0, 1'b0, 1'b0);
`else
    checkOut("reset_hold", 32'd8, 1'b1, 1'b0);
`endif
    @(negedge clock);
    ctrl_reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      applyOp(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sh);
      checkOut(vecs[i].name, vecs[i].expResult, vecs[i].expNe, vecs[i].expLt);
    end

    // Back-to-back operations with inputs changing every cycle.
    applyModel("b2b_0", 32'h0000_0010, 32'h0000_0020, 5'd1, 5'd0);
    applyModel("b2b_1", 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd0);
    applyModel("b2b_2", 32'h8765_4321, 32'h0000_0000, 5'd5, 5'd16);

    // Reset asserted away from any clock edge.
    @(posedge clock);
    #(halfPeriod / 2.0);
    ctrl_reset = 1'b0;
    #0.5;
`ifdef ALU_OUTPUT_REG_EN
    checkOut("async_reset", 32'd0, 1'b0, 1'b0);
`else
    checkOut("async_reset", 32'h8765_4321 >> 16 | 32'hFFFF_0000, 1'b1, 1'b1);
`endif
    @(negedge clock);
    ctrl_reset = 1'b1;

    // Random regression at each clock rate.
    for (int k = 0; k < 4; k++) begin
      halfPeriod = periods[k] / 2.0;
      for (int op = 0; op < 6; op++) begin
        for (int i = 0; i < 16; i++) begin
          logic [31:0] a;
          logic [31:0] b;
          a = $urandom;
          b = $urandom;
          if (i == 0) a = 32'h8000_0000 | (a & 32'h0000_FFFF);
          applyModel("rand_ab", a, b, 5'(op), 5'(i));
          applyModel("rand_ba", b, a, 5'(op), 5'(i));
          applyModel("rand_aa", a, a, 5'(op), 5'(i));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

`default_nettype wire
